// File: rtl/axi_read_arbiter_if.sv
// axi_read_arbiter_if: CPU-side inst/data request ports plus the AXI AR/R channels.
// The arbiter connects through slave; the requesters and the AXI memory connect through master.
interface axi_read_arbiter_if;
    logic        inst_req;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;

    modport slave (
        input  inst_req, inst_size, inst_addr, data_req, data_size, data_addr,
        input  arready, rid, rdata, rvalid,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output arid, araddr, arsize, arvalid, rready
    );

    modport master (
        output inst_req, inst_size, inst_addr, data_req, data_size, data_addr,
        output arready, rid, rdata, rvalid,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  arid, araddr, arsize, arvalid, rready
    );
endinterface

// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: merges instruction and data read requests onto one AXI read port,
// data side first, with a single read outstanding at a time.
module axi_read_arbiter #(
    parameter logic [3:0] INST_ID = 4'd0,
    parameter logic [3:0] DATA_ID = 4'd1
) (
    input logic               aclk,
    input logic               aresetn,
    axi_read_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ADDR, WAIT, RESP} state_t;

    state_t      r_state;
    logic        r_owner;
    logic        r_arvalid;
    logic        r_rready;
    logic        r_inst_ok;
    logic        r_data_ok;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic [31:0] r_rdata;
    logic        w_idle;
    logic        w_hit;
    logic [3:0]  w_id;

    // Grant is combinational in IDLE; gating with aresetn keeps it quiet while reset is held.
    assign w_idle            = aresetn && r_state == IDLE;
    assign w_id              = r_owner ? DATA_ID : INST_ID;
    assign w_hit             = bus.rvalid && bus.rid == w_id;
    assign bus.data_addr_ok  = w_idle && bus.data_req;
    assign bus.inst_addr_ok  = w_idle && bus.inst_req && !bus.data_req;
    assign bus.arvalid       = r_arvalid;
    assign bus.araddr        = r_addr;
    assign bus.arsize        = {1'b0, r_size};
    assign bus.arid          = r_arvalid ? w_id : 4'd0;
    assign bus.rready        = r_rready;
    assign bus.inst_data_ok  = r_inst_ok;
    assign bus.data_data_ok  = r_data_ok;
    assign bus.inst_rdata    = r_rdata;
    assign bus.data_rdata    = r_rdata;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state   <= IDLE;
            r_owner   <= 1'b0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_inst_ok <= 1'b0;
            r_data_ok <= 1'b0;
            r_addr    <= '0;
            r_size    <= '0;
            r_rdata   <= '0;
        end else begin
            case (r_state)
                IDLE: if (bus.data_req || bus.inst_req) begin
                    r_owner   <= bus.data_req;
                    r_addr    <= bus.data_req ? bus.data_addr : bus.inst_addr;
                    r_size    <= bus.data_req ? bus.data_size : bus.inst_size;
                    r_arvalid <= 1'b1;
                    r_state   <= ADDR;
                end
                ADDR: if (bus.arready) begin
                    r_arvalid <= 1'b0;
                    r_rready  <= 1'b1;
                    r_state   <= WAIT;
                end
                // Beats carrying another ID are accepted via rready and dropped.
                WAIT: if (w_hit) begin
                    r_rdata   <= bus.rdata;
                    r_rready  <= 1'b0;
                    r_inst_ok <= !r_owner;
                    r_data_ok <= r_owner;
                    r_state   <= RESP;
                end
                RESP: begin
                    r_inst_ok <= 1'b0;
                    r_data_ok <= 1'b0;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb_axi_read_arbiter: transaction-level model of the arbiter driven with random requests,
// AR back-pressure and stray R beats, plus directed reset and boundary cases.
module tb_axi_read_arbiter;
    logic aclk;
    logic aresetn;
    int   n_checks;
    int   n_errors;
    logic        pend;
    logic [31:0] pend_addr;
    logic [1:0]  pend_size;

    axi_read_arbiter_if bus ();

    axi_read_arbiter dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic outs(input string ph, input logic av, input logic rr, input logic iao,
                        input logic dao, input logic ido, input logic ddo);
        check({ph, ".arvalid"}, bus.arvalid, av);
        check({ph, ".rready"}, bus.rready, rr);
        check({ph, ".inst_addr_ok"}, bus.inst_addr_ok, iao);
        check({ph, ".data_addr_ok"}, bus.data_addr_ok, dao);
        check({ph, ".inst_data_ok"}, bus.inst_data_ok, ido);
        check({ph, ".data_data_ok"}, bus.data_data_ok, ddo);
    endtask

    task automatic next();
        @(posedge aclk);
        #1;
    endtask

    // One full read starting in IDLE; returns with the arbiter back in IDLE.
    task automatic run_txn(input logic ireq, input logic dreq, input logic [31:0] iaddr,
                           input logic [1:0] isize, input logic [31:0] daddr,
                           input logic [1:0] dsize, input int ar_dly, input int junk,
                           input logic [31:0] rd, input logic keep);
        logic        own;
        logic [31:0] eaddr;
        logic [2:0]  esize;
        logic [3:0]  eid;
        logic [3:0]  bad;
        own   = dreq;
        eaddr = dreq ? daddr : iaddr;
        esize = {1'b0, dreq ? dsize : isize};
        eid   = dreq ? 4'd1 : 4'd0;
        bus.inst_req  = ireq;
        bus.inst_addr = iaddr;
        bus.inst_size = isize;
        bus.data_req  = dreq;
        bus.data_addr = daddr;
        bus.data_size = dsize;
        bus.arready   = 1'b0;
        bus.rvalid    = 1'b0;
        @(negedge aclk);
        outs("grant", 1'b0, 1'b0, ireq && !dreq, dreq, 1'b0, 1'b0);
        next();
        pend = keep && ireq && dreq;
        pend_addr = iaddr;
        pend_size = isize;
        bus.inst_req  = pend;
        bus.data_addr = $urandom;
        bus.data_size = 2'($urandom_range(0, 2));
        if (!pend) bus.inst_addr = $urandom;
        for (int i = 0; i <= ar_dly; i++) begin
            bus.arready  = (i == ar_dly);
            bus.data_req = 1'($urandom);
            @(negedge aclk);
            outs("addr", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            check("addr.araddr", bus.araddr, eaddr);
            check("addr.arsize", 32'(bus.arsize), 32'(esize));
            check("addr.arid", 32'(bus.arid), 32'(eid));
            next();
        end
        bus.arready = 1'b0;
        for (int j = 0; j <= junk; j++) begin
            bad = 4'd2;
            if (j > 0) begin
                bad = 4'($urandom_range(0, 15));
                while (bad == eid) bad = 4'($urandom_range(0, 15));
            end
            bus.rvalid   = 1'b1;
            bus.rid      = (j == junk) ? eid : bad;
            bus.rdata    = (j == junk) ? rd : $urandom;
            bus.data_req = 1'($urandom);
            @(negedge aclk);
            outs("wait", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            next();
        end
        bus.rvalid   = 1'b0;
        bus.rdata    = $urandom;
        bus.data_req = 1'($urandom);
        @(negedge aclk);
        outs("resp", 1'b0, 1'b0, 1'b0, 1'b0, !own, own);
        check(own ? "resp.data_rdata" : "resp.inst_rdata", own ? bus.data_rdata : bus.inst_rdata, rd);
        next();
        bus.data_req = 1'b0;
    endtask

    task automatic reset_outs(input string ph);
        outs(ph, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check({ph, ".araddr"}, bus.araddr, 32'd0);
        check({ph, ".arsize"}, 32'(bus.arsize), 32'd0);
        check({ph, ".arid"}, 32'(bus.arid), 32'd0);
        check({ph, ".inst_rdata"}, bus.inst_rdata, 32'd0);
        check({ph, ".data_rdata"}, bus.data_rdata, 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        pend     = 1'b0;
        aresetn  = 1'b1;
        bus.inst_req = 1'b1;
        bus.data_req = 1'b1;
        bus.inst_addr = 32'h1234;
        bus.data_addr = 32'h5678;
        bus.inst_size = 2'd2;
        bus.data_size = 2'd2;
        bus.arready = 1'b0;
        bus.rvalid = 1'b0;
        bus.rid = 4'd0;
        bus.rdata = 32'd0;
        #2 aresetn = 1'b0;
        #1 reset_outs("rst");
        next();
        reset_outs("rst_hold");
        bus.inst_req = 1'b0;
        bus.data_req = 1'b0;
        aresetn = 1'b1;
        next();

        run_txn(1'b1, 1'b0, 32'hBFC00000, 2'd2, 32'h0, 2'd0, 0, 0, 32'h3C080001, 1'b0);
        run_txn(1'b1, 1'b1, 32'hBFC00010, 2'd2, 32'h1000, 2'd2, 0, 0, 32'hCAFE0001, 1'b1);
        run_txn(1'b1, 1'b0, pend_addr, pend_size, 32'h0, 2'd0, 0, 0, 32'hCAFE0002, 1'b0);
        run_txn(1'b0, 1'b1, 32'h0, 2'd0, 32'h2000, 2'd2, 5, 0, 32'h11112222, 1'b0);
        run_txn(1'b0, 1'b1, 32'h0, 2'd0, 32'h3000, 2'd1, 0, 1, 32'h33334444, 1'b0);
        run_txn(1'b0, 1'b1, 32'h0, 2'd0, 32'h1003, 2'd0, 0, 0, 32'h000000AB, 1'b0);

        // Reset during WAIT abandons the data read.
        bus.data_req = 1'b1;
        bus.data_addr = 32'h4000;
        bus.data_size = 2'd2;
        next();
        bus.data_req = 1'b0;
        bus.arready = 1'b1;
        next();
        bus.arready = 1'b0;
        @(negedge aclk);
        outs("pre_rst", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 aresetn = 1'b0;
        bus.inst_req = 1'b1;
        bus.data_req = 1'b1;
        bus.rvalid = 1'b1;
        bus.rid = 4'd1;
        bus.rdata = 32'hDEADBEEF;
        #1 reset_outs("mid_rst");
        next();
        reset_outs("mid_rst_hold");
        bus.inst_req = 1'b0;
        bus.data_req = 1'b0;
        bus.rvalid = 1'b0;
        aresetn = 1'b1;
        @(negedge aclk);
        outs("post_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        next();
        run_txn(1'b1, 1'b0, 32'hBFC00100, 2'd2, 32'h0, 2'd0, 0, 0, 32'h55AA55AA, 1'b0);

        for (int t = 0; t < 40; t++) begin
            logic ir, dr;
            logic [31:0] ia;
            logic [1:0]  is;
            ir = pend ? 1'b1 : 1'($urandom);
            dr = 1'($urandom);
            if (!ir && !dr) dr = 1'b1;
            ia = pend ? pend_addr : $urandom;
            is = pend ? pend_size : 2'($urandom_range(0, 2));
            run_txn(ir, dr, ia, is, $urandom, 2'($urandom_range(0, 2)),
                    $urandom_range(0, 3), $urandom_range(0, 2), $urandom, 1'($urandom));
        end
        if (pend) run_txn(1'b1, 1'b0, pend_addr, pend_size, 32'h0, 2'd0, 0, 0, 32'h0BADF00D, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/axi_read_arbiter.md
AXI_READ_ARBITER -- requirements
Module: axi_read_arbiter

Interface
REQ-001 Parameter INST_ID, default 4'd0: ARID used for instruction-side reads.
REQ-002 Parameter DATA_ID, default 4'd1: ARID used for data-side reads.
REQ-003 aclk  input  1  single clock; all state updates on its rising edge.
REQ-004 aresetn  input  1  asynchronous active-low reset.
REQ-005 inst_req  input  1  instruction-side read request.
REQ-006 inst_size  input  2  instruction read size: 0 = byte, 1 = half, 2 = word.
REQ-007 inst_addr  input  32  instruction read address.
REQ-008 inst_addr_ok  output  1  instruction request accepted this cycle.
REQ-009 inst_data_ok  output  1  inst_rdata valid this cycle.
REQ-010 inst_rdata  output  32  instruction read data.
REQ-011 data_req, data_size, data_addr, data_addr_ok, data_data_ok, data_rdata: same directions, widths and meanings as REQ-005..010, for the data side.
REQ-012 arid  output  4; araddr  output  32; arsize  output  3; arvalid  output  1; arready  input  1: AXI read-address channel.
REQ-013 rid  input  4; rdata  input  32; rvalid  input  1; rready  output  1: AXI read-data channel.

Function
REQ-014 FSM states SHALL be IDLE, ADDR, WAIT and RESP, with exactly one read outstanding at a time.
REQ-015 IDLE: a request SHALL be granted combinationally, with data priority: data_req set -> data_addr_ok=1; otherwise inst_req set -> inst_addr_ok=1.
REQ-016 A grant SHALL latch the winner's addr, size and owner flag, and move to ADDR next cycle.
REQ-017 addr_ok SHALL be 0 in every state other than IDLE, and never asserted for both sides in the same cycle.
REQ-018 ADDR: arvalid SHALL be 1; araddr = latched addr; arsize = {1'b0, latched size}; arid = DATA_ID or INST_ID per owner.
REQ-019 ADDR: AR outputs SHALL stay stable until arready; arvalid & arready -> WAIT next cycle.
REQ-020 WAIT: rready SHALL be 1; rready SHALL be 0 in all other states.
REQ-021 WAIT: rvalid with rid equal to the outstanding ID SHALL capture rdata into a 32-bit register and move to RESP.
REQ-022 WAIT: rvalid with a mismatched rid SHALL be consumed and discarded; state stays WAIT.
REQ-023 RESP: the owner's data_ok SHALL be 1 for exactly one cycle, with its rdata equal to the captured word; next state is IDLE.
REQ-024 inst_rdata and data_rdata SHALL both drive the capture register; they are qualified only by their data_ok.
REQ-025 Minimum latency SHALL be 4 cycles from grant to data_ok: grant (IDLE) -> ADDR with arready=1 -> WAIT with rvalid=1 -> RESP.
REQ-026 The cycle after RESP is IDLE, where a pending request is granted; back-to-back throughput SHALL be one read per 4 cycles.
REQ-027 A request deasserted while another side's transaction is in flight SHALL have no effect; only requests present in IDLE are considered.
REQ-028 Simultaneous inst_req and data_req in IDLE SHALL grant data; inst keeps waiting and is granted at the next IDLE if still asserted.

Reset
REQ-029 aresetn low SHALL immediately force IDLE, clear the owner flag, capture register and latched addr/size to 0, and hold all outputs at 0.
REQ-030 Reset asserted mid-transaction (ADDR/WAIT/RESP) SHALL abandon it without data_ok; the first cycle after release is IDLE.

Verification
REQ-031 inst_req=1, inst_addr=0xBFC00000, size=2, arready=1 at once, rvalid next cycle with rid=0, rdata=0x3C080001 -> inst_addr_ok in cycle 0, arvalid/araddr=0xBFC00000/arsize=2/arid=0 in cycle 1, inst_data_ok with inst_rdata=0x3C080001 in cycle 3.
REQ-032 inst_req and data_req both 1 in IDLE, data_addr=0x1000 -> data_addr_ok only, arid=1; inst granted in the IDLE after data_data_ok.
REQ-033 arready held low for 5 cycles in ADDR -> arvalid, araddr, arsize and arid remain constant all 5 cycles; WAIT entered only after arready.
REQ-034 In WAIT, rvalid with rid=2, then with rid=1 (data outstanding) -> first beat discarded with no data_ok; second beat gives data_data_ok with its rdata.
REQ-035 aresetn pulsed low during WAIT -> all outputs 0 immediately; no data_ok; a new request after release is granted normally.
REQ-036 data_size=0, data_addr=0x1003 -> arsize=3'b000 and araddr=0x1003 passed through unaltered.
